// File: rtl/pot_scheduler_pkg.sv
// Shared FSM encoding, slot/channel table and limits for the slider scan scheduler.
package pot_scheduler_pkg;

   typedef enum logic [1:0] {IDLE, START, WAIT, STORE} state_t;

   localparam int          NUM_SLOTS     = 6;
   localparam logic [2:0]  LAST_SLOT     = 3'(NUM_SLOTS - 1);
   localparam logic [11:0] TIMEOUT_LIMIT = 12'd4095;

   // Slot n's channel code sits in bits [3n+2:3n]: slots 0..5 -> 1,0,4,2,3,7.
   localparam logic [3*NUM_SLOTS-1:0] SLOT_CHNL = {3'd7, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1};

   typedef struct packed {
      logic       hit;
      logic [2:0] slot;
   } slot_lkp_t;

   function automatic logic [2:0] slot_to_chnl(input logic [2:0] slot);
      return SLOT_CHNL[3*int'(slot) +: 3];
   endfunction

   function automatic slot_lkp_t chnl_to_slot(input logic [2:0] chnl);
      slot_lkp_t r;
      r = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (SLOT_CHNL[3*i +: 3] == chnl) begin
            r.hit  = 1'b1;
            r.slot = 3'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/pot_avg.sv
// New slider value from the previous value and a fresh A2D sample.
// POT_AVG_EN selects (3*old + sample) >> 2 with truncation; otherwise the raw sample is stored.
module pot_avg (
   input  logic [11:0] old_val,
   input  logic [11:0] sample,
   output logic [11:0] new_val
);

`ifdef POT_AVG_EN
   logic [13:0] sum;
   logic [1:0]  unused_frac;

   // 3*4095 + 4095 = 16380 still fits in 14 bits, so no overflow.
   assign sum = 14'(old_val) * 14'd3 + 14'(sample);
   assign {new_val, unused_frac} = sum;
`else
   logic unused_old;

   assign unused_old = ^old_val;
   assign new_val    = sample;
`endif

endmodule

// File: rtl/pot_scheduler.sv
// Round-robin A2D scan of six sliders with an interleaved host priority conversion.
// Build with POT_AVG_EN defined to low-pass filter each stored slider value.
module pot_scheduler
   import pot_scheduler_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   output logic        strt_cnv,
   output logic [2:0]  chnnl,
   input  logic        cnv_cmplt,
   input  logic [11:0] res,
   input  logic        pri_req,
   input  logic [2:0]  pri_chnl,
   output logic        pri_busy,
   output logic        pri_ack,
   output logic [11:0] pri_data,
   output logic [11:0] POT_LP,
   output logic [11:0] POT_B1,
   output logic [11:0] POT_B2,
   output logic [11:0] POT_B3,
   output logic [11:0] POT_HP,
   output logic [11:0] VOLUME,
   output logic        sweep_done,
   output logic        err
);

   state_t      state;
   logic [2:0]  slot;
   logic [11:0] tmo_cnt;
   logic [11:0] res_q;
   logic        cur_pri;
   logic [2:0]  pri_chnl_q;
   logic [11:0] pots [NUM_SLOTS];

   slot_lkp_t   lkp;
   logic        tgt_vld;
   logic [2:0]  tgt_slot;
   logic [11:0] store_val;

   // chnnl is held through STORE, so it names the register a priority result lands in.
   assign lkp = chnl_to_slot(chnnl);

   always_comb begin
      tgt_vld  = 1'b1;
      tgt_slot = slot;
      if (cur_pri) begin
         tgt_vld  = lkp.hit;
         tgt_slot = lkp.hit ? lkp.slot : 3'd0;
      end
   end

   pot_avg u_pot_avg (
      .old_val (pots[tgt_slot]),
      .sample  (res_q),
      .new_val (store_val)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         slot       <= '0;
         tmo_cnt    <= '0;
         res_q      <= '0;
         cur_pri    <= 1'b0;
         pri_chnl_q <= '0;
         chnnl      <= '0;
         strt_cnv   <= 1'b0;
         pri_busy   <= 1'b0;
         pri_ack    <= 1'b0;
         pri_data   <= '0;
         sweep_done <= 1'b0;
         err        <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            pots[i] <= '0;
         end
      end else begin
         strt_cnv   <= 1'b0;
         pri_ack    <= 1'b0;
         sweep_done <= 1'b0;
         err        <= 1'b0;

         // A request in the pri_ack cycle is dropped, so the host must re-request.
         if (pri_req && !pri_busy && !pri_ack) begin
            pri_busy   <= 1'b1;
            pri_chnl_q <= pri_chnl;
         end

         case (state)
            IDLE: begin
               tmo_cnt  <= '0;
               strt_cnv <= 1'b1;
               state    <= START;
               // Never two priority conversions back to back: the scan keeps moving.
               if (pri_busy && !cur_pri) begin
                  cur_pri <= 1'b1;
                  chnnl   <= pri_chnl_q;
               end else begin
                  cur_pri <= 1'b0;
                  chnnl   <= slot_to_chnl(slot);
               end
            end

            START: begin
               state <= WAIT;
            end

            WAIT: begin
               if (cnv_cmplt) begin
                  res_q <= res;
                  state <= STORE;
               end else if (tmo_cnt == TIMEOUT_LIMIT) begin
                  err   <= 1'b1;
                  state <= IDLE;
                  if (cur_pri) begin
                     pri_busy <= 1'b0;
                  end else begin
                     slot <= (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 12'd1;
               end
            end

            STORE: begin
               state <= IDLE;
               if (tgt_vld) begin
                  pots[tgt_slot] <= store_val;
               end
               if (cur_pri) begin
                  pri_ack  <= 1'b1;
                  pri_data <= res_q;
                  pri_busy <= 1'b0;
               end else begin
                  sweep_done <= (slot == LAST_SLOT);
                  slot       <= (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign POT_LP = pots[0];
   assign POT_B1 = pots[1];
   assign POT_B2 = pots[2];
   assign POT_B3 = pots[3];
   assign POT_HP = pots[4];
   assign VOLUME = pots[5];

endmodule

// File: tb/tb_pot_scheduler.sv
// Randomised bench for pot_scheduler: an A2D responder plus a transaction-level model of the
// scan order, priority interleave, timeout and store rules; every output is checked against it.
module tb_pot_scheduler;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        strt_cnv;
   logic [2:0]  chnnl;
   logic        cnv_cmplt = 1'b0;
   logic [11:0] res       = '0;
   logic        pri_req   = 1'b0;
   logic [2:0]  pri_chnl  = '0;
   logic        pri_busy;
   logic        pri_ack;
   logic [11:0] pri_data;
   logic [11:0] POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME;
   logic        sweep_done;
   logic        err;

   pot_scheduler dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .strt_cnv   (strt_cnv),
      .chnnl      (chnnl),
      .cnv_cmplt  (cnv_cmplt),
      .res        (res),
      .pri_req    (pri_req),
      .pri_chnl   (pri_chnl),
      .pri_busy   (pri_busy),
      .pri_ack    (pri_ack),
      .pri_data   (pri_data),
      .POT_LP     (POT_LP),
      .POT_B1     (POT_B1),
      .POT_B2     (POT_B2),
      .POT_B3     (POT_B3),
      .POT_HP     (POT_HP),
      .VOLUME     (VOLUME),
      .sweep_done (sweep_done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   int chan_of_slot [6] = '{1, 0, 4, 2, 3, 7};
`ifdef POT_AVG_EN
   int sweep1_exp [6] = '{1, 26, 51, 76, 101, 126};
   int avg_exp    [3] = '{1000, 1750, 2312};
`else
   int sweep1_exp [6] = '{5, 105, 205, 305, 405, 505};
   int avg_exp    [3] = '{4000, 4000, 4000};
`endif

   // model state
   int m_pot [6];
   int m_slot, m_pchnl, m_pri_data;
   bit m_last_pri, m_busy, m_ack_prev;
   bit prev_req;
   int prev_chnl;

   // the one conversion in flight
   bit c_act, c_pri, c_tmo;
   int c_start, c_cmplt_at, c_chnl, c_slot, c_res;

   // stimulus knobs
   int pri_mode, res_mode;
   bit fixed_dly, spur_en, tmo_next;

   int n_events, n_ack_seen, n_sweep_seen, first_chnl;
   bit want_first;

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      if (obs != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int slot_of(input int ch);
      for (int i = 0; i < 6; i++) begin
         if (chan_of_slot[i] == ch) return i;
      end
      return -1;
   endfunction

   function automatic int upd(input int old, input int r);
`ifdef POT_AVG_EN
      return (3 * old + r) / 4;
`else
      return r + 0 * old;
`endif
   endfunction

   function automatic int dut_pot(input int i);
      case (i)
         0:       return int'(POT_LP);
         1:       return int'(POT_B1);
         2:       return int'(POT_B2);
         3:       return int'(POT_B3);
         4:       return int'(POT_HP);
         default: return int'(VOLUME);
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 6; i++) m_pot[i] = 0;
      m_slot = 0; m_pchnl = 0; m_pri_data = 0;
      m_last_pri = 0; m_busy = 0; m_ack_prev = 0;
      prev_req = 0; prev_chnl = 0;
      c_act = 0; c_pri = 0; c_tmo = 0;
   endtask

   task automatic check_reset_outputs();
      chk("rst_strt_cnv", int'(strt_cnv), 0);
      chk("rst_chnnl", int'(chnnl), 0);
      chk("rst_pri_busy", int'(pri_busy), 0);
      chk("rst_pri_ack", int'(pri_ack), 0);
      chk("rst_pri_data", int'(pri_data), 0);
      chk("rst_sweep_done", int'(sweep_done), 0);
      chk("rst_err", int'(err), 0);
      for (int i = 0; i < 6; i++) chk("rst_pot", dut_pot(i), 0);
   endtask

   // One clock: observe at the falling edge, compare with the model, then drive next inputs.
   task automatic step();
      bit exp_ack, exp_sweep, exp_err, clr, ev, saw_strt;
      int idx;
      @(negedge clk);
      cyc++;
      exp_ack = 0; exp_sweep = 0; exp_err = 0; clr = 0; ev = 0; saw_strt = 0;

      if (c_act && !c_tmo && cyc == c_cmplt_at + 1) chk("chnnl_hold", int'(chnnl), c_chnl);
      if (c_act && !c_tmo && cyc == c_cmplt_at + 2) begin
         if (c_pri) begin
            exp_ack    = 1;
            clr        = 1;
            m_pri_data = c_res;
            idx        = slot_of(c_chnl);
            if (idx >= 0) m_pot[idx] = upd(m_pot[idx], c_res);
         end else begin
            m_pot[c_slot] = upd(m_pot[c_slot], c_res);
            exp_sweep     = (c_slot == 5);
            m_slot        = (m_slot + 1) % 6;
         end
         c_act = 0; ev = 1; n_events++;
      end
      if (c_act && c_tmo && cyc == c_start + 4097) begin
         exp_err = 1;
         if (c_pri) clr = 1;
         else m_slot = (m_slot + 1) % 6;
         c_act = 0; ev = 1; n_events++;
      end

      chk("pri_ack", int'(pri_ack), int'(exp_ack));
      chk("sweep_done", int'(sweep_done), int'(exp_sweep));
      chk("err", int'(err), int'(exp_err));
      if (exp_ack) chk("pri_data", int'(pri_data), m_pri_data);
      if (ev) begin
         for (int i = 0; i < 6; i++) chk("pot_value", dut_pot(i), m_pot[i]);
      end
      if (pri_ack) n_ack_seen++;
      if (sweep_done) n_sweep_seen++;

      if (strt_cnv) begin
         saw_strt = 1;
         chk("strt_overlap", int'(c_act), 0);
         c_pri  = m_busy && !m_last_pri;
         c_chnl = c_pri ? m_pchnl : chan_of_slot[m_slot];
         chk("strt_chnnl", int'(chnnl), c_chnl);
         if (want_first) begin
            first_chnl = int'(chnnl);
            want_first = 0;
         end
         c_act      = 1;
         c_start    = cyc;
         c_slot     = m_slot;
         m_last_pri = c_pri;
         c_tmo      = tmo_next;
         tmo_next   = 0;
         c_cmplt_at = cyc + (fixed_dly ? 40 : int'($urandom_range(1, 60)));
         if (res_mode == 1 && !c_pri) c_res = c_slot * 100 + 5;
         else if (res_mode == 2 && !c_pri && c_slot == 0) c_res = 4000;
         else c_res = int'($urandom_range(0, 4095));
      end

      if (clr) m_busy = 0;
      else if (!m_busy && prev_req && !m_ack_prev) begin
         m_busy  = 1;
         m_pchnl = prev_chnl;
      end
      chk("pri_busy", int'(pri_busy), int'(m_busy));
      m_ack_prev = exp_ack;

      cnv_cmplt = 1'b0;
      res       = 12'($urandom);
      if (c_act && !c_tmo && cyc == c_cmplt_at) begin
         cnv_cmplt = 1'b1;
         res       = 12'(c_res);
      end else if (spur_en && (saw_strt || (c_act && !c_tmo && cyc == c_cmplt_at + 1))
                   && $urandom_range(0, 1) == 1) begin
         cnv_cmplt = 1'b1;
      end

      case (pri_mode)
         1: begin
            pri_req  = ($urandom_range(0, 9) == 0);
            pri_chnl = 3'($urandom);
         end
         2: begin
            pri_req  = 1'b1;
            pri_chnl = 3'd5;
         end
         3: begin
            pri_req  = c_act && !c_pri && c_slot == 2 &&
                       (cyc == c_start + 5 || cyc == c_start + 12);
            pri_chnl = (cyc == c_start + 5) ? 3'd7 : 3'd3;
         end
         default: pri_req = 1'b0;
      endcase
      prev_req  = pri_req;
      prev_chnl = int'(pri_chnl);
   endtask

   task automatic run_events(input int n, input int budget);
      int target, t0;
      target = n_events + n;
      t0     = cyc;
      while (n_events < target && cyc - t0 < budget) step();
      if (n_events < target) chk("event_budget", n_events, target);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: still running at %0t, required to finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acks0, guard;
      model_reset();
      pri_mode = 0; res_mode = 1; fixed_dly = 1; spur_en = 0; tmo_next = 0;
      n_events = 0; n_ack_seen = 0; n_sweep_seen = 0; want_first = 0; first_chnl = -1;

      step();
      step();
      check_reset_outputs();
      rst_n = 1'b1;

      // first full sweep with res = slot*100 + 5
      run_events(6, 1000);
      chk("sweep_done_count", n_sweep_seen, 1);
      for (int i = 0; i < 6; i++) chk("sweep1_pot", dut_pot(i), sweep1_exp[i]);

      // priority channel 7 requested during slot 2, second request while busy
      pri_mode = 3;
      acks0    = n_ack_seen;
      run_events(5, 1000);
      chk("pri_ack_count", n_ack_seen - acks0, 1);

      // continuous channel-5 requests interleave with the scan
      pri_mode = 2; res_mode = 0; fixed_dly = 0; spur_en = 1;
      run_events(10, 2000);
      pri_mode = 0;
      run_events(2, 500);

      // withheld completion times out
      tmo_next = 1;
      run_events(2, 4500);

      // random mix of requests, delays and stray completions
      pri_mode = 1;
      run_events(40, 4000);
      pri_mode = 0;
      run_events(2, 500);

      // reset in the middle of a WAIT
      fixed_dly = 1; spur_en = 0;
      guard = 0;
      while (!(c_act && !c_tmo && cyc == c_start + 10) && guard < 600) begin
         step();
         guard++;
      end
      if (guard >= 600) chk("reach_wait", guard, 0);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      model_reset();
      res_mode = 2;
      step();
      step();
      rst_n      = 1'b1;
      want_first = 1;

      // three sweeps feeding 4000 into slot 0 from a cleared register
      for (int s = 0; s < 3; s++) begin
         run_events(6, 1000);
         chk("pot_lp_sweep", int'(POT_LP), avg_exp[s]);
      end
      chk("post_reset_chnnl", first_chnl, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
